// File: rtl/pattern_detector_pkg.sv
// Shared types, reset defaults and length clamp for the serial pattern detector.
package pattern_detector_pkg;

    typedef enum logic {
        S_FILL  = 1'b0,
        S_ARMED = 1'b1
    } state_e;

    localparam logic [5:0]  DEFAULT_PAT = 6'b110110;
    localparam int unsigned DEFAULT_LEN = 6;

    // Length 0 means 1; anything above the history depth saturates to it.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        if (len == 0)
            return 1;
        else if (len > max_len)
            return max_len;
        else
            return len;
    endfunction

endpackage

// File: rtl/pattern_detector_if.sv
// Serial sample, pattern-load and match-report signals of the pattern detector.
interface pattern_detector_if #(
    parameter int unsigned PAT_W = 6,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned LEN_W = $clog2(PAT_W + 1);

    logic               en;
    logic               x;
    logic               overlap;
    logic               pat_load;
    logic [PAT_W-1:0]   pat_in;
    logic [LEN_W-1:0]   pat_len;
    logic               z;
    logic               armed;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output en, x, overlap, pat_load, pat_in, pat_len,
        input  z, armed, match_cnt
    );

    modport slave (
        input  en, x, overlap, pat_load, pat_in, pat_len,
        output z, armed, match_cnt
    );

endinterface

// File: rtl/pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         i_clr_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!i_clr_n)
            r_cnt <= '0;
        else if (i_inc && (r_cnt != '1))
            r_cnt <= r_cnt + W'(1);
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pattern_detector.sv
// Serial pattern detector: runtime-loadable pattern, overlap select, en qualifier,
// armed flag and saturating match count.
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter int unsigned      PAT_W       = 6,
    parameter int unsigned      CNT_W       = 8,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(pattern_detector_pkg::DEFAULT_PAT),
    parameter int unsigned      DEFAULT_LEN = pattern_detector_pkg::DEFAULT_LEN
) (
    input  logic              clk,
    input  logic              reset,
    pattern_detector_if.slave bus
);

    localparam int unsigned LEN_W = $clog2(PAT_W + 1);
    localparam logic [LEN_W-1:0] RST_LEN = LEN_W'(clamp_len(DEFAULT_LEN, PAT_W));

    state_e           r_state;
    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic             r_z;

    state_e           w_state_n;
    logic [PAT_W-1:0] w_hist_n;
    logic [LEN_W-1:0] w_fill_n;
    logic [PAT_W-1:0] w_pat_n;
    logic [LEN_W-1:0] w_len_n;
    logic             w_z_n;
    logic             w_inc;

    logic [PAT_W-1:0] w_shift;
    logic [LEN_W-1:0] w_fill_inc;
    logic [PAT_W-1:0] w_mask;
    logic             w_hit;

    // Candidate history after consuming x, and the compare over the low len bits.
    assign w_shift    = {r_hist[PAT_W-2:0], bus.x};
    assign w_fill_inc = (r_fill == LEN_W'(PAT_W)) ? r_fill : r_fill + LEN_W'(1);
    assign w_mask     = (PAT_W'(1) << r_len) - PAT_W'(1);
    assign w_hit      = (w_fill_inc >= r_len) && ((w_shift & w_mask) == (r_pat & w_mask));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_FILL;
            r_hist  <= '0;
            r_fill  <= '0;
            r_pat   <= DEFAULT_PAT;
            r_len   <= RST_LEN;
            r_z     <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_hist  <= w_hist_n;
            r_fill  <= w_fill_n;
            r_pat   <= w_pat_n;
            r_len   <= w_len_n;
            r_z     <= w_z_n;
        end
    end

    // Next state: pattern load wins over sampling; en=0 freezes everything but z.
    always_comb begin
        w_state_n = r_state;
        w_hist_n  = r_hist;
        w_fill_n  = r_fill;
        w_pat_n   = r_pat;
        w_len_n   = r_len;
        w_z_n     = 1'b0;
        w_inc     = 1'b0;

        if (bus.pat_load) begin
            w_pat_n   = bus.pat_in;
            w_len_n   = LEN_W'(clamp_len(32'(bus.pat_len), PAT_W));
            w_hist_n  = '0;
            w_fill_n  = '0;
            w_state_n = S_FILL;
        end else if (bus.en) begin
            w_hist_n = w_shift;
            w_z_n    = w_hit;
            w_inc    = w_hit;
            if (w_hit && !bus.overlap) begin
                // Consumed bits may not seed the next match.
                w_fill_n  = '0;
                w_state_n = S_FILL;
            end else begin
                w_fill_n = w_fill_inc;
                if (w_fill_inc >= r_len)
                    w_state_n = S_ARMED;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk     (clk),
        .i_clr_n (reset),
        .i_inc   (w_inc),
        .o_cnt   (bus.match_cnt)
    );

    assign bus.z     = r_z;
    assign bus.armed = (r_state == S_ARMED);

endmodule

// File: tb/tb_pattern_detector.sv
// Scoreboard bench: two detectors (CNT_W=8 and CNT_W=2) share one stimulus stream.
module tb_pattern_detector;

    localparam int unsigned PAT_W = 6;
    localparam int unsigned LEN_W = 3;

    typedef struct {
        int z;
        int armed;
        int cnt_a;
        int cnt_b;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pattern_detector_if #(.PAT_W(PAT_W), .CNT_W(8)) bus_a ();
    pattern_detector_if #(.PAT_W(PAT_W), .CNT_W(2)) bus_b ();

    pattern_detector #(.PAT_W(PAT_W), .CNT_W(8)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    pattern_detector #(.PAT_W(PAT_W), .CNT_W(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_step   = 0;
    exp_t sb_q[$];

    // Reference model: bit list is compared bit-by-bit against the pattern.
    logic [PAT_W-1:0] m_hist;
    logic [PAT_W-1:0] m_pat;
    int m_fill, m_len, m_cnt_a, m_cnt_b, m_z;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model(input logic rst_n, input logic en, input logic x, input logic ov,
                         input logic load, input logic [PAT_W-1:0] pin, input logic [LEN_W-1:0] plen);
        int f;
        int hit;
        if (!rst_n) begin
            m_hist = '0; m_fill = 0; m_z = 0; m_cnt_a = 0; m_cnt_b = 0;
            m_pat = 6'b110110; m_len = 6;
        end else if (load) begin
            m_pat  = pin;
            m_len  = (plen == 0) ? 1 : ((int'(plen) > 6) ? 6 : int'(plen));
            m_hist = '0; m_fill = 0; m_z = 0;
        end else if (en) begin
            m_hist = {m_hist[PAT_W-2:0], x};
            f = (m_fill + 1 > 6) ? 6 : m_fill + 1;
            hit = 0;
            if (f >= m_len) begin
                hit = 1;
                for (int i = 0; i < m_len; i++)
                    if (m_hist[i] != m_pat[i]) hit = 0;
            end
            m_z = hit;
            if (hit != 0) begin
                if (m_cnt_a < 255) m_cnt_a++;
                if (m_cnt_b < 3)   m_cnt_b++;
            end
            m_fill = (hit != 0 && !ov) ? 0 : f;
        end else begin
            m_z = 0;
        end
    endtask

    task automatic step(input logic rst_n, input logic en, input logic x, input logic ov,
                        input logic load, input logic [PAT_W-1:0] pin, input logic [LEN_W-1:0] plen);
        exp_t e;
        exp_t p;
        reset = rst_n;
        bus_a.en = en; bus_a.x = x; bus_a.overlap = ov; bus_a.pat_load = load;
        bus_a.pat_in = pin; bus_a.pat_len = plen;
        bus_b.en = en; bus_b.x = x; bus_b.overlap = ov; bus_b.pat_load = load;
        bus_b.pat_in = pin; bus_b.pat_len = plen;
        model(rst_n, en, x, ov, load, pin, plen);
        e.z = m_z; e.armed = (m_fill >= m_len) ? 1 : 0; e.cnt_a = m_cnt_a; e.cnt_b = m_cnt_b;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        n_step++;
        p = sb_q.pop_front();
        check($sformatf("s%0d.z_a", n_step),     int'(bus_a.z),         p.z);
        check($sformatf("s%0d.armed_a", n_step), int'(bus_a.armed),     p.armed);
        check($sformatf("s%0d.cnt_a", n_step),   int'(bus_a.match_cnt), p.cnt_a);
        check($sformatf("s%0d.z_b", n_step),     int'(bus_b.z),         p.z);
        check($sformatf("s%0d.armed_b", n_step), int'(bus_b.armed),     p.armed);
        check($sformatf("s%0d.cnt_b", n_step),   int'(bus_b.match_cnt), p.cnt_b);
    endtask

    task automatic bits(input logic ov, input logic [7:0] seq, input int n);
        for (int i = n - 1; i >= 0; i--)
            step(1'b1, 1'b1, seq[i], ov, 1'b0, '0, '0);
    endtask

    task automatic load(input logic [PAT_W-1:0] pin, input logic [LEN_W-1:0] plen);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, pin, plen);
    endtask

    initial begin
        // Reset, then check the reset state is held.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'h3f, 3'd2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

        // 110, overlap: hits after bits 3 and 6.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'b000110, 3'd3);
        bits(1'b1, 8'b110110, 6);

        // 11 with and without overlap.
        load(6'b000011, 3'd2);
        bits(1'b1, 8'b1111, 4);
        load(6'b000011, 3'd2);
        bits(1'b0, 8'b1111, 4);

        // Default pattern after reset with en gaps between bits.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 5; i >= 0; i--) begin
            step(1'b1, 1'b1, (i == 3 || i == 0) ? 1'b0 : 1'b1, 1'b1, 1'b0, '0, '0);
            step(1'b1, 1'b0, 1'($urandom_range(1)), 1'b1, 1'b0, '0, '0);
        end

        // Mid-stream load with en=1 drops that x; then 1011 hits once.
        bits(1'b1, 8'b101, 3);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'b001011, 3'd4);
        bits(1'b1, 8'b1011, 4);

        // len=1 (via pat_len=0 clamp): five hits, narrow counter saturates.
        load(6'b111111, 3'd0);
        bits(1'b0, 8'b11111, 5);
        load(6'b000001, 3'd1);
        bits(1'b1, 8'b01, 2);

        // Over-length clamps to 6; upper pattern bits ignored for short len.
        load(6'b110110, 3'd7);
        bits(1'b1, 8'b110110, 6);
        load(6'b111110, 3'd3);
        bits(1'b0, 8'b1101110, 7);

        // Reset mid-pattern; full pattern required afterwards.
        load(6'b110110, 3'd6);
        bits(1'b1, 8'b11, 2);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, '0);
        bits(1'b1, 8'b0, 1);
        bits(1'b1, 8'b110110, 6);

        // Random stream with random pattern/overlap/en.
        load(6'b000101, 3'd3);
        for (int i = 0; i < 120; i++) begin
            if (i % 40 == 39)
                load(6'($urandom), 3'($urandom_range(7)));
            else
                step(1'b1, 1'($urandom_range(3) != 0), 1'($urandom_range(1)),
                     1'($urandom_range(1)), 1'b0, '0, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
